// File: rtl/px_frame_sequencer.sv
// rtl/px_frame_sequencer.sv - frame timing controller: erase/expose/convert/per-row read strobes
module px_frame_sequencer #(
    parameter int c_erase   = 5,
    parameter int c_expose  = 255,
    parameter int c_convert = 255,
    parameter int c_read    = 5,
    parameter int nRows     = 3,
    localparam int RW       = (nRows > 1) ? $clog2(nRows) : 1
) (
    input  logic          clk,
    input  logic          rst,
    output logic          expose,
    output logic          erase,
    output logic          read,
    output logic          convert,
    output logic [RW-1:0] readReg
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ERASE   = 3'd1,
        EXPOSE  = 3'd2,
        CONVERT = 3'd3,
        READ    = 3'd4
    } state_t;

    localparam logic [15:0]   lastErase   = 16'(c_erase - 1);
    localparam logic [15:0]   lastExpose  = 16'(c_expose - 1);
    localparam logic [15:0]   lastConvert = 16'(c_convert - 1);
    localparam logic [15:0]   lastRead    = 16'(c_read - 1);
    localparam logic [RW-1:0] lastRow     = RW'(nRows - 1);

    state_t        state, stateNext;
    logic [15:0]   cnt, cntNext;
    logic [RW-1:0] rowNext;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 16'd0;
            readReg <= '0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            readReg <= rowNext;
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt + 16'd1;
        rowNext   = readReg;
        case (state)
            IDLE: begin
                stateNext = ERASE;
                cntNext   = 16'd0;
            end
            ERASE: begin
                if (cnt == lastErase) begin
                    stateNext = EXPOSE;
                    cntNext   = 16'd0;
                end
            end
            EXPOSE: begin
                if (cnt == lastExpose) begin
                    stateNext = CONVERT;
                    cntNext   = 16'd0;
                end
            end
            CONVERT: begin
                if (cnt == lastConvert) begin
                    stateNext = READ;
                    cntNext   = 16'd0;
                    rowNext   = '0;
                end
            end
            READ: begin
                // Row boundaries clear the counter but keep the READ state, so read never drops between rows.
                if (cnt == lastRead) begin
                    cntNext = 16'd0;
                    if (readReg == lastRow) begin
                        stateNext = ERASE;
                        rowNext   = '0;
                    end else begin
                        rowNext = readReg + RW'(1);
                    end
                end
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 16'd0;
                rowNext   = '0;
            end
        endcase
    end

    assign erase   = (state == ERASE);
    assign expose  = (state == EXPOSE);
    assign convert = (state == CONVERT);
    assign read    = (state == READ);

endmodule

// File: tb/tb_px_frame_sequencer.sv
// tb/tb_px_frame_sequencer.sv - self-checking bench for px_frame_sequencer (default and minimal timings)
module tb_px_frame_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       eraseA, exposeA, convertA, readA;
    logic [1:0] rowA;
    logic       eraseB, exposeB, convertB, readB;
    logic [0:0] rowB;

    px_frame_sequencer dutA (
        .clk(clk), .rst(rst),
        .expose(exposeA), .erase(eraseA), .read(readA), .convert(convertA),
        .readReg(rowA)
    );

    px_frame_sequencer #(
        .c_erase(1), .c_expose(2), .c_convert(3), .c_read(1), .nRows(1)
    ) dutB (
        .clk(clk), .rst(rst),
        .expose(exposeB), .erase(eraseB), .read(readB), .convert(convertB),
        .readReg(rowB)
    );

    int nChecks = 0;
    int nFails  = 0;
    int k       = 0;

    // Rising edges seen since the last reset release; 0 means still in reset or IDLE.
    always @(posedge clk or negedge rst) begin
        if (!rst) k <= 0;
        else      k <= k + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s: got %h, expected %h (k=%0d, t=%0t)", name, act, req, k, $time);
        end
    endtask

    // Expected {erase,expose,convert,read,row[7:0]} from the frame timing rules.
    function automatic logic [11:0] model(input int kk, input int ce, input int cx,
                                          input int cv, input int cr, input int nr);
        int p;
        if (kk == 0) return 12'h000;
        p = (kk - 1) % (ce + cx + cv + nr * cr);
        if (p < ce)           return {4'b1000, 8'd0};
        if (p < ce + cx)      return {4'b0100, 8'd0};
        if (p < ce + cx + cv) return {4'b0010, 8'd0};
        return {4'b0001, 8'((p - ce - cx - cv) / cr)};
    endfunction

    function automatic logic [11:0] outA();
        return {eraseA, exposeA, convertA, readA, 6'd0, rowA};
    endfunction

    function automatic logic [11:0] outB();
        return {eraseB, exposeB, convertB, readB, 7'd0, rowB};
    endfunction

    always @(negedge clk) begin
        check("modelA", 32'(outA()), 32'(model(k, 5, 255, 255, 5, 3)));
        check("modelB", 32'(outB()), 32'(model(k, 1, 2, 3, 1, 1)));
        check("onehotA", 32'($countones({eraseA, exposeA, convertA, readA}) <= 1), 32'd1);
        check("onehotB", 32'($countones({eraseB, exposeB, convertB, readB}) <= 1), 32'd1);
    end

    typedef struct {
        int         at;
        bit         selB;
        logic [3:0] strobes;
        logic [7:0] row;
    } vec_t;

    vec_t vecs[23];

    initial begin
        int n;
        int guard;
        vecs[0]  = '{1,    1'b0, 4'b1000, 8'd0};
        vecs[1]  = '{1,    1'b1, 4'b1000, 8'd0};
        vecs[2]  = '{2,    1'b1, 4'b0100, 8'd0};
        vecs[3]  = '{3,    1'b1, 4'b0100, 8'd0};
        vecs[4]  = '{4,    1'b1, 4'b0010, 8'd0};
        vecs[5]  = '{5,    1'b0, 4'b1000, 8'd0};
        vecs[6]  = '{6,    1'b0, 4'b0100, 8'd0};
        vecs[7]  = '{6,    1'b1, 4'b0010, 8'd0};
        vecs[8]  = '{7,    1'b1, 4'b0001, 8'd0};
        vecs[9]  = '{8,    1'b1, 4'b1000, 8'd0};
        vecs[10] = '{14,   1'b1, 4'b0001, 8'd0};
        vecs[11] = '{15,   1'b1, 4'b1000, 8'd0};
        vecs[12] = '{260,  1'b0, 4'b0100, 8'd0};
        vecs[13] = '{261,  1'b0, 4'b0010, 8'd0};
        vecs[14] = '{515,  1'b0, 4'b0010, 8'd0};
        vecs[15] = '{516,  1'b0, 4'b0001, 8'd0};
        vecs[16] = '{520,  1'b0, 4'b0001, 8'd0};
        vecs[17] = '{521,  1'b0, 4'b0001, 8'd1};
        vecs[18] = '{526,  1'b0, 4'b0001, 8'd2};
        vecs[19] = '{530,  1'b0, 4'b0001, 8'd2};
        vecs[20] = '{531,  1'b0, 4'b1000, 8'd0};
        vecs[21] = '{1060, 1'b0, 4'b0001, 8'd2};
        vecs[22] = '{1061, 1'b0, 4'b1000, 8'd0};

        // Reset held: everything quiet.
        repeat (4) @(negedge clk);
        check("resetA", 32'(outA()), 32'd0);
        check("resetB", 32'(outB()), 32'd0);
        #3 rst = 1'b1;

        foreach (vecs[i]) begin
            guard = 0;
            while (k < vecs[i].at && guard < 5000) begin
                @(negedge clk);
                guard++;
            end
            check("vec_reached", 32'(k), 32'(vecs[i].at));
            if (vecs[i].selB) check($sformatf("vecB@%0d", vecs[i].at), 32'(outB()), 32'({vecs[i].strobes, vecs[i].row}));
            else              check($sformatf("vecA@%0d", vecs[i].at), 32'(outA()), 32'({vecs[i].strobes, vecs[i].row}));
        end

        // Asynchronous reset in the middle of expose.
        guard = 0;
        while (((k - 1) % 530) != 100 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        check("mid_expose_before", 32'(exposeA), 32'd1);
        #3 rst = 1'b0;
        #1 check("mid_expose_async", 32'(outA()), 32'd0);
        check("mid_expose_asyncB", 32'(outB()), 32'd0);
        repeat (3) @(negedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        n = 0;
        while (eraseA && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("erase_len_after_reset", 32'(n), 32'd5);
        n = 0;
        while (exposeA && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("expose_len_after_reset", 32'(n), 32'd255);

        // Random reset pulses at random points in the frame.
        for (int r = 0; r < 12; r++) begin
            repeat ($urandom_range(1, 1200)) @(negedge clk);
            #($urandom_range(1, 4)) rst = 1'b0;
            #1 check("rand_async", 32'({outA(), outB()}), 32'd0);
            repeat ($urandom_range(1, 4)) @(negedge clk);
            #3 rst = 1'b1;
        end
        repeat (1100) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
